// File: rtl/wt_cache_pkg.sv
// Shared types and helpers for the write-through cache invalidation path.
// Kept small so both the snoop front end and any future consumers agree on encodings.
package wt_cache_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        EXPAND = 1'b1
    } inval_gen_state_e;

    // Widest address the helpers handle; callers zero-extend narrower addresses.
    localparam int unsigned MaxAddrWidth = 64;

    // Cache-line index of a byte address for a line of 2**offs bytes.
    function automatic logic [MaxAddrWidth-1:0] line_of(
        input logic [MaxAddrWidth-1:0] addr,
        input int unsigned             offs
    );
        return addr >> offs;
    endfunction

endpackage

// File: rtl/wt_inval_fifo.sv
// In-order invalidation queue holding line indices.
// Exposes both the head (issue side) and the tail (merge compare) entries.
module wt_inval_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 60
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] head_o,
    output logic [Width-1:0] tail_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PtrW = $clog2(Depth);

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wr_ptr;
    logic [PtrW-1:0]  rd_ptr;
    logic [PtrW:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count == (PtrW+1)'(Depth));
    assign empty_o = (count == '0);

    // A push never bypasses a full queue, even when a pop happens the same cycle.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    assign head_o = mem[rd_ptr];
    assign tail_o = mem[wr_ptr - PtrW'(1)];

    // NOTE: storage has no reset; only the pointers and count qualify its contents.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= data_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PtrW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PtrW+1)'(1);
                2'b01:   count <= count - (PtrW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wt_inval_gen.sv
// Snoops non-coherent write bursts and turns each into a stream of D$ line invalidations,
// merging repeats of the most recently queued line.
module wt_inval_gen
    import wt_cache_pkg::*;
#(
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned LineBytes = 16,
    parameter int unsigned FifoDepth = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 enable_i,
    input  logic                 snoop_valid_i,
    output logic                 snoop_ready_o,
    input  logic [AddrWidth-1:0] snoop_addr_i,
    input  logic [7:0]           snoop_len_i,
    input  logic [2:0]           snoop_size_i,
    output logic [AddrWidth-1:0] inval_addr_o,
    output logic                 inval_valid_o,
    input  logic                 inval_ready_i,
    output logic                 busy_o,
    output logic [31:0]          inval_cnt_o,
    output logic [31:0]          merged_cnt_o
);

    localparam int unsigned Offs  = $clog2(LineBytes);
    localparam int unsigned LineW = AddrWidth - Offs;

    inval_gen_state_e state;
    logic [LineW-1:0] cur_line;
    logic [LineW-1:0] end_line;

    logic             snoop_hs;
    logic [15:0]      span_bytes;
    logic [AddrWidth:0] end_byte;
    logic [LineW-1:0] start_line_d;
    logic [LineW-1:0] end_line_d;
    logic [MaxAddrWidth-1:0] start_line_full;

    logic [LineW-1:0] q_head;
    logic [LineW-1:0] q_tail;
    logic             q_full;
    logic             q_empty;
    logic             merge;
    logic             push;
    logic             pop;
    logic             advance;

    assign snoop_ready_o = (state == IDLE) && enable_i;
    assign snoop_hs      = snoop_valid_i && snoop_ready_o;

    // Burst byte span is at most 256 beats of 128 bytes, so 16 bits suffice.
    assign span_bytes      = (16'(snoop_len_i) + 16'd1) << snoop_size_i;
    assign start_line_full = line_of(MaxAddrWidth'(snoop_addr_i), Offs);
    assign start_line_d    = start_line_full[LineW-1:0];

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        end_byte   = '0;
        end_line_d = '0;
        end_byte   = {1'b0, snoop_addr_i} + (AddrWidth+1)'(span_bytes) - (AddrWidth+1)'(1);
        if (end_byte[AddrWidth]) begin
            end_line_d = '1;  // burst runs past the top of memory: clamp instead of wrapping
        end else begin
            end_line_d = end_byte[AddrWidth-1:Offs];
        end
    end

    // Only the newest queued entry is a merge candidate; popped lines are re-issued.
    assign merge   = (state == EXPAND) && !q_empty && (q_tail == cur_line);
    assign push    = (state == EXPAND) && !merge && !q_full;
    assign advance = merge || push;
    assign pop     = inval_valid_o && inval_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            cur_line <= '0;
            end_line <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (snoop_hs) begin
                        cur_line <= start_line_d;
                        end_line <= end_line_d;
                        state    <= EXPAND;
                    end
                end
                EXPAND: begin
                    if (advance) begin
                        if (cur_line == end_line) begin
                            state <= IDLE;
                        end else begin
                            cur_line <= cur_line + LineW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inval_cnt_o  <= '0;
            merged_cnt_o <= '0;
        end else begin
            if (pop && (inval_cnt_o != '1)) begin
                inval_cnt_o <= inval_cnt_o + 32'd1;
            end
            if (merge && (merged_cnt_o != '1)) begin
                merged_cnt_o <= merged_cnt_o + 32'd1;
            end
        end
    end

    wt_inval_fifo #(
        .Depth (FifoDepth),
        .Width (LineW)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .data_i  (cur_line),
        .pop_i   (pop),
        .head_o  (q_head),
        .tail_o  (q_tail),
        .full_o  (q_full),
        .empty_o (q_empty)
    );

    // Head storage is unreset, so the address is forced to zero while the queue is empty.
    assign inval_valid_o = !q_empty;
    assign inval_addr_o  = q_empty ? '0 : {q_head, Offs'(0)};
    assign busy_o        = (state != IDLE) || !q_empty;

endmodule

// File: tb/tb_wt_inval_gen.sv
// Directed bench for wt_inval_gen with LineBytes=16, FifoDepth=4.
module tb_wt_inval_gen;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        enable_i;
    logic        snoop_valid_i;
    logic        snoop_ready_o;
    logic [63:0] snoop_addr_i;
    logic [7:0]  snoop_len_i;
    logic [2:0]  snoop_size_i;
    logic [63:0] inval_addr_o;
    logic        inval_valid_o;
    logic        inval_ready_i;
    logic        busy_o;
    logic [31:0] inval_cnt_o;
    logic [31:0] merged_cnt_o;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    wt_inval_gen #(
        .AddrWidth (64),
        .LineBytes (16),
        .FifoDepth (4)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .enable_i      (enable_i),
        .snoop_valid_i (snoop_valid_i),
        .snoop_ready_o (snoop_ready_o),
        .snoop_addr_i  (snoop_addr_i),
        .snoop_len_i   (snoop_len_i),
        .snoop_size_i  (snoop_size_i),
        .inval_addr_o  (inval_addr_o),
        .inval_valid_o (inval_valid_o),
        .inval_ready_i (inval_ready_i),
        .busy_o        (busy_o),
        .inval_cnt_o   (inval_cnt_o),
        .merged_cnt_o  (merged_cnt_o)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a burst and hold it until accepted (bounded), then drop valid.
    task automatic snoop(input logic [63:0] addr, input logic [7:0] len, input logic [2:0] size);
        logic ok;
        ok            = 1'b0;
        snoop_valid_i = 1'b1;
        snoop_addr_i  = addr;
        snoop_len_i   = len;
        snoop_size_i  = size;
        for (int i = 0; i < 50; i++) begin
            if (snoop_ready_o) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check("snoop_accepted", 64'(ok), 64'd1);
        tick();
        snoop_valid_i = 1'b0;
    endtask

    // Wait (bounded) for a valid head, compare its address, then pop it.
    task automatic expect_pop(input string tag, input logic [63:0] exp_addr);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (inval_valid_o) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check({tag, "_valid"}, 64'(seen), 64'd1);
        if (seen) begin
            check(tag, inval_addr_o, exp_addr);
            inval_ready_i = 1'b1;
            tick();
            inval_ready_i = 1'b0;
        end
    endtask

    initial begin
        rst_i         = 1'b1;
        enable_i      = 1'b1;
        snoop_valid_i = 1'b0;
        snoop_addr_i  = '0;
        snoop_len_i   = '0;
        snoop_size_i  = '0;
        inval_ready_i = 1'b0;
        tick();
        tick();
        rst_i = 1'b0;

        check("rst_valid",  64'(inval_valid_o), 64'd0);
        check("rst_addr",   inval_addr_o, 64'd0);
        check("rst_busy",   64'(busy_o), 64'd0);
        check("rst_icnt",   64'(inval_cnt_o), 64'd0);
        check("rst_mcnt",   64'(merged_cnt_o), 64'd0);
        check("rst_sready", 64'(snoop_ready_o), 64'd1);

        enable_i = 1'b0;
        #1;
        check("disabled_sready", 64'(snoop_ready_o), 64'd0);
        enable_i = 1'b1;
        #1;

        // Single line; first push one cycle after accept, valid the cycle after.
        snoop(64'h0000_0000_8000_0004, 8'd0, 3'd3);
        check("t1_lat_n1_valid", 64'(inval_valid_o), 64'd0);
        check("t1_lat_n1_busy",  64'(busy_o), 64'd1);
        tick();
        check("t1_lat_n2_valid", 64'(inval_valid_o), 64'd1);
        check("t1_icnt_before",  64'(inval_cnt_o), 64'd0);
        expect_pop("t1_addr", 64'h0000_0000_8000_0000);
        check("t1_icnt", 64'(inval_cnt_o), 64'd1);

        // Two beats straddling a line boundary.
        snoop(64'h1008, 8'd1, 3'd3);
        expect_pop("t2_first",  64'h1000);
        expect_pop("t2_second", 64'h1010);
        check("t2_busy", 64'(busy_o), 64'd0);
        check("t2_icnt", 64'(inval_cnt_o), 64'd3);

        // Eight lines with the sink stalled: queue fills and the FSM waits.
        snoop(64'h2000, 8'd15, 3'd3);
        for (int i = 0; i < 8; i++) tick();
        check("t3_stall_sready", 64'(snoop_ready_o), 64'd0);
        check("t3_stall_busy",   64'(busy_o), 64'd1);
        check("t3_stall_head",   inval_addr_o, 64'h2000);
        for (int i = 0; i < 8; i++) begin
            expect_pop($sformatf("t3_line%0d", i), 64'h2000 + 64'(i) * 64'h10);
        end
        tick();
        check("t3_busy",   64'(busy_o), 64'd0);
        check("t3_sready", 64'(snoop_ready_o), 64'd1);
        check("t3_icnt",   64'(inval_cnt_o), 64'd11);

        // Same-line repeat merges into the queued tail; after the pop it is issued again.
        snoop(64'h3000, 8'd0, 3'd3);
        tick();
        snoop(64'h3008, 8'd0, 3'd3);
        tick();
        tick();
        check("t4_mcnt", 64'(merged_cnt_o), 64'd1);
        expect_pop("t4_first", 64'h3000);
        check("t4_empty_after_pop", 64'(inval_valid_o), 64'd0);
        snoop(64'h3000, 8'd0, 3'd3);
        expect_pop("t4_reissue", 64'h3000);
        check("t4_mcnt_after", 64'(merged_cnt_o), 64'd1);
        check("t4_icnt",       64'(inval_cnt_o), 64'd13);

        // Burst crossing the top of the address space clamps to the last line.
        snoop(64'hFFFF_FFFF_FFFF_FFF8, 8'd3, 3'd3);
        expect_pop("t5_top", 64'hFFFF_FFFF_FFFF_FFF0);
        tick();
        tick();
        check("t5_no_wrap_valid", 64'(inval_valid_o), 64'd0);
        check("t5_busy",          64'(busy_o), 64'd0);
        check("t5_icnt",          64'(inval_cnt_o), 64'd14);

        // Reset mid-expansion drops everything.
        snoop(64'h2000, 8'd15, 3'd3);
        tick();
        tick();
        check("t6_pre_busy", 64'(busy_o), 64'd1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("t6_valid",  64'(inval_valid_o), 64'd0);
        check("t6_addr",   inval_addr_o, 64'd0);
        check("t6_busy",   64'(busy_o), 64'd0);
        check("t6_icnt",   64'(inval_cnt_o), 64'd0);
        check("t6_mcnt",   64'(merged_cnt_o), 64'd0);
        check("t6_sready", 64'(snoop_ready_o), 64'd1);
        tick();
        tick();
        check("t6_no_drain", 64'(inval_valid_o), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
